serial_subtractor: RTL

//   Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   It is the inverse-direction companion of the combinational full-adder adder chain.

---
 rtl/serial_subtractor.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b - bin), LSB first, one bit per clock.
// Optional signed-overflow flag and its MSB capture enabled by defining SERIAL_SUB_OVF_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a new operation; start captures a/b/bin
// S_RUN  | one subtract bit per clock; down-counter tracks bits left
// S_DONE | result valid and held until ack
module serial_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             ack,
   output logic             ready,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sa, sb, sd, sd_nxt;
   logic             br, br_nxt, d, last;

   assign d      = sa[0] ^ sb[0] ^ br;
   assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign last   = (cnt == '0);

   generate
      if (WIDTH == 1) begin : g_sd_w1
         assign sd_nxt = d;
      end else begin : g_sd_wn
         assign sd_nxt = {d, sd[WIDTH-1:1]};
      end
   endgenerate

   assign ready = (state == S_IDLE);
   assign busy  = (state == S_RUN);
   assign valid = (state == S_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last)  state_nxt = S_DONE;
         S_DONE:  if (ack)   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb, b_msb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == S_IDLE && start) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (state == S_RUN && last) begin
         // d on the final bit is the result MSB
         ovf <= (a_msb ^ b_msb) & (a_msb ^ d);
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa   <= '0;
         sb   <= '0;
         sd   <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sa  <= a;
                  sb  <= b;
                  br  <= bin;
                  cnt <= CNT_LOAD;
               end
            end
            S_RUN: begin
               br  <= br_nxt;
               sd  <= sd_nxt;
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               cnt <= cnt - 1'b1;
               if (last) begin
                  diff <= sd_nxt;
                  bout <= br_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
